// File: rtl/mcycle_ctrl_pkg.sv
// Shared types and constants for the EX-stage multi-cycle controller.
package mcycle_ctrl_pkg;

    // Divider sequencer states: free, divide-by-zero shortcut, stepping, result held
    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

    localparam int STALL_BUS_W = 6;

    // Stall vector bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
    localparam logic [STALL_BUS_W-1:0] STALL_NONE  = 6'b000000;
    localparam logic [STALL_BUS_W-1:0] STALL_TO_ID = 6'b000111;
    localparam logic [STALL_BUS_W-1:0] STALL_TO_EX = 6'b001111;

endpackage

// File: rtl/mcycle_ctrl_div_seq.sv
// Radix-2 restoring divider sequencer: FSM, step counter, {rem,quot} shift
// register and final sign correction for signed divides.
module div_seq
    import mcycle_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                annul,
    input  logic                sgn,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic [2*DATA_W-1:0] result,
    output logic                ready
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_e          state, state_nxt;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W:0]   rq;        // {rem (DATA_W+1), quot (DATA_W)}
    logic [DATA_W-1:0]   dvs;
    logic                sgn_q, neg_a, neg_b;

    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     cand;
    logic [DATA_W+1:0]   diff;
    logic [2*DATA_W:0]   rq_step;
    logic [DATA_W-1:0]   quot, rem, quot_fix, rem_fix;

    // Operand magnitudes, one restoring step, and the sign-corrected result
    always_comb begin
        abs_a    = (sgn && op_a[DATA_W-1]) ? -op_a : op_a;
        abs_b    = (sgn && op_b[DATA_W-1]) ? -op_b : op_b;
        // Shift {rem,quot} left by one: the quotient MSB moves into the remainder
        cand     = rq[2*DATA_W-1:DATA_W-1];
        diff     = {rq[2*DATA_W], cand} - {2'b00, dvs};
        if (diff[DATA_W+1])
            rq_step = {cand, rq[DATA_W-2:0], 1'b0};
        else
            rq_step = {diff[DATA_W:0], rq[DATA_W-2:0], 1'b1};
        quot     = rq[DATA_W-1:0];
        rem      = rq[2*DATA_W-1:DATA_W];
        quot_fix = (sgn_q && (neg_a ^ neg_b)) ? -quot : quot;
        rem_fix  = neg_a ? -rem : rem;
    end

    // Next-state decode; annul or a dropped start abandons any divide in flight
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_FREE: begin
                if (start && !annul)
                    state_nxt = (op_b == '0) ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: begin
                if (annul || !start) state_nxt = DIV_FREE;
                else                 state_nxt = DIV_END;
            end
            DIV_ON: begin
                if (annul || !start)                      state_nxt = DIV_FREE;
                else if (count == CNT_W'(DATA_W - 1))      state_nxt = DIV_END;
            end
            DIV_END: begin
                if (!start) state_nxt = DIV_FREE;
            end
            default: state_nxt = DIV_FREE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DIV_FREE;
        else     state <= state_nxt;
    end

    // Datapath: latch operands, step the shift register, publish the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rq     <= '0;
            dvs    <= '0;
            sgn_q  <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (start && !annul && op_b != '0) begin
                        dvs   <= abs_b;
                        rq    <= {{(DATA_W+1){1'b0}}, abs_a};
                        count <= '0;
                        sgn_q <= sgn;
                        neg_a <= sgn & op_a[DATA_W-1];
                        neg_b <= sgn & op_b[DATA_W-1];
                    end
                end
                DIV_BYZERO: begin
                    // Zero quotient and remainder; negating zero keeps it zero
                    rq <= '0;
                end
                DIV_ON: begin
                    if (!annul && start) begin
                        rq    <= rq_step;
                        count <= count + 1'b1;
                    end
                end
                DIV_END: begin
                    if (start) begin
                        result <= {rem_fix, quot_fix};
                        ready  <= 1'b1;
                    end else begin
                        result <= '0;
                        ready  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// EX-stage multi-cycle controller: divider sequencing plus pipeline stall
// arbitration (EX requests outrank ID requests; mem/wb never stall).
module mcycle_ctrl
    import mcycle_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                stallreq_id_i,
    input  logic                stallreq_ex_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic [STALL_W-1:0]  stall_o
);

    logic div_stall;

    div_seq #(.DATA_W(DATA_W)) u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (start_i),
        .annul  (annul_i),
        .sgn    (signed_i),
        .op_a   (opdata1_i),
        .op_b   (opdata2_i),
        .result (result_o),
        .ready  (ready_o)
    );

    // Stall arbitration; reset forces the vector low without waiting for a clock
    always_comb begin
        div_stall = start_i & ~ready_o & ~annul_i;
        stall_o   = STALL_W'(STALL_NONE);
        if (rst)
            stall_o = STALL_W'(STALL_NONE);
        else if (stallreq_ex_i || div_stall)
            stall_o = STALL_W'(STALL_TO_EX);
        else if (stallreq_id_i)
            stall_o = STALL_W'(STALL_TO_ID);
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: spec vectors, stall table, annul/reset
// corner sequences and randomized divides against an arithmetic model.
module tb_mcycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, annul_i, signed_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        stallreq_id_i, stallreq_ex_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic [5:0]  stall_o;

    int tests = 0;
    int fails = 0;

    mcycle_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .signed_i(signed_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
        .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } div_vec_t;

    typedef struct {
        bit         id;
        bit         ex;
        bit         start;
        bit         annul;
        logic [5:0] exp;
    } stall_vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; x/0 yields 0
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic run_div(input string nm, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int  n;
        bit  stall_ok;
        n = -1;
        stall_ok = 1'b1;
        @(negedge clk);
        signed_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin n = k; break; end
            if (stall_o !== 6'b001111) stall_ok = 1'b0;
        end
        chk($sformatf("%s.latency", nm), 64'(n), 64'(lat));
        chk($sformatf("%s.result", nm), result_o, exp);
        chk($sformatf("%s.stall_busy", nm), 64'(stall_ok), 64'd1);
        chk($sformatf("%s.stall_ready", nm), 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("%s.hold", nm), {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s.release", nm), {63'd0, ready_o} | result_o, 64'd0);
    endtask

    div_vec_t   dv[$];
    stall_vec_t sv[$];

    initial begin
        rst = 1'b1; start_i = 0; annul_i = 0; signed_i = 0;
        opdata1_i = 0; opdata2_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0;

        dv.push_back('{0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33});
        dv.push_back('{1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33});
        dv.push_back('{1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           33});
        dv.push_back('{0, 32'hDEADBEEF,   32'd1,          {32'd0, 32'hDEADBEEF},           33});
        dv.push_back('{1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           33});
        dv.push_back('{1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},          33});
        dv.push_back('{0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0, 32'd1},                  33});
        dv.push_back('{0, 32'd3,          32'd10,         {32'd3, 32'd0},                  33});
        dv.push_back('{0, 32'd5,          32'd0,          64'd0,                           2});
        dv.push_back('{1, 32'h80000000,   32'd0,          64'd0,                           2});

        sv.push_back('{0, 0, 0, 0, 6'b000000});
        sv.push_back('{1, 0, 0, 0, 6'b000111});
        sv.push_back('{0, 1, 0, 0, 6'b001111});
        sv.push_back('{1, 1, 0, 0, 6'b001111});
        sv.push_back('{1, 0, 1, 1, 6'b000111});
        sv.push_back('{0, 0, 1, 1, 6'b000000});

        // Reset state
        #12;
        chk("reset.outputs", {result_o[62:0], ready_o}, 64'd0);
        chk("reset.stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stall arbitration with no divide running
        foreach (sv[i]) begin
            @(negedge clk);
            stallreq_id_i = sv[i].id; stallreq_ex_i = sv[i].ex;
            start_i = sv[i].start; annul_i = sv[i].annul;
            #1;
            chk($sformatf("stall[%0d]", i), 64'(stall_o), 64'(sv[i].exp));
        end
        @(negedge clk);
        stallreq_id_i = 0; stallreq_ex_i = 0; start_i = 0; annul_i = 0;
        @(posedge clk); #1;
        chk("stall.no_start", 64'(ready_o), 64'd0);

        // Directed divides
        foreach (dv[i])
            run_div($sformatf("vec[%0d]", i), dv[i].sgn, dv[i].a, dv[i].b, dv[i].exp, dv[i].lat);

        // Annul at step 10: abandons the divide, ready never rises
        begin
            bit seen = 1'b0;
            @(negedge clk);
            signed_i = 0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
            repeat (11) @(posedge clk);
            @(negedge clk);
            annul_i = 1'b1;
            #1;
            chk("annul.stall", 64'(stall_o), 64'd0);
            @(negedge clk);
            annul_i = 1'b0; start_i = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (ready_o) seen = 1'b1;
            end
            chk("annul.no_ready", 64'(seen), 64'd0);
            run_div("after_annul", 0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        end

        // Async reset mid-RUN
        begin
            bit seen = 1'b0;
            @(negedge clk);
            signed_i = 1; opdata1_i = 32'hFFFFFF9C; opdata2_i = 32'd7; start_i = 1'b1;
            repeat (15) @(posedge clk);
            #3 rst = 1'b1;
            #1;
            chk("rst_run.ready", 64'(ready_o), 64'd0);
            chk("rst_run.stall", 64'(stall_o), 64'd0);
            @(negedge clk); start_i = 1'b0;
            @(negedge clk); rst = 1'b0;
            repeat (5) begin
                @(posedge clk); #1;
                if (ready_o || result_o != 64'd0) seen = 1'b1;
            end
            chk("rst_run.quiet", 64'(seen), 64'd0);
        end

        // Async reset while a result is being held
        @(negedge clk);
        signed_i = 0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (36) @(posedge clk);
        #1;
        chk("rst_done.pre", {ready_o, result_o[62:0]}, {1'b1, 31'd1, 32'd333});
        #2 rst = 1'b1;
        #1;
        chk("rst_done.clear", {63'd0, ready_o} | result_o, 64'd0);
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Randomized divides against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            bit          s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'd0;
                3:       b = -$urandom_range(1, 20);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div($sformatf("rand[%0d]", i), s, a, b, model(s, a, b), (b == 0) ? 2 : 33);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
